// File: rtl/secuenciador_notas_if.sv
// Bus between the note sequencer and its surroundings (melody/duration ROMs, tone stage, control).
//   play, pause, loop_en : run controls (levels)
//   duracion_nota        : duration table output for direccion_nota (combinational lookup)
//   direccion_nota       : current note address
//   contador_tiempo      : cycles elapsed in the current note
//   sonando              : tone gate, 1 = sound
//   fin                  : one-cycle end-of-melody pulse
// master = control/ROM side, slave = sequencer.
interface secuenciador_notas_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DUR_W  = 4
);
  logic              play;
  logic              pause;
  logic              loop_en;
  logic [DUR_W-1:0]  duracion_nota;
  logic [ADDR_W-1:0] direccion_nota;
  logic [23:0]       contador_tiempo;
  logic              sonando;
  logic              fin;

  modport master (
    output play, pause, loop_en, duracion_nota,
    input  direccion_nota, contador_tiempo, sonando, fin
  );

  modport slave (
    input  play, pause, loop_en, duracion_nota,
    output direccion_nota, contador_tiempo, sonando, fin
  );
endinterface

// File: rtl/secuenciador_notas.sv
// Note sequencer. Steps a note address through the melody ROM, holds each note for
// duracion_nota*TICK_DIV cycles (plus one load cycle) and mutes the last GAP_CYC cycles of every
// note so repeated notes stay distinct.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : secuenciador_notas_if.slave (controls and duration in, address/counter/gate/fin out)
// All outputs are registered.
module secuenciador_notas #(
  parameter int unsigned NUM_NOTAS = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DUR_W     = 4,
  parameter int unsigned TICK_DIV  = 750000,
  parameter int unsigned GAP_CYC   = 60000
) (
  input logic                 clk,
  input logic                 rst,
  secuenciador_notas_if.slave bus
);

  localparam logic [23:0]       TickDiv    = 24'(TICK_DIV);
  localparam logic [23:0]       GapCyc     = 24'(GAP_CYC);
  localparam logic [ADDR_W-1:0] UltimaNota = ADDR_W'(NUM_NOTAS - 1);

  typedef enum logic [2:0] {StIdle, StCarga, StNota, StSilencio, StFin} estado_e;

  estado_e           estado_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       cuenta_q;
  logic [23:0]       largo_q;
  logic              sonando_q;
  logic              fin_q;

  logic [23:0] largo_nuevo;
  logic [23:0] fin_sonido;
  logic [23:0] fin_nota;
  logic        activo;

  always_comb begin
    largo_nuevo = 24'(bus.duracion_nota) * TickDiv;
    fin_sonido  = largo_q - GapCyc - 24'd1;  // last sounding cycle
    fin_nota    = largo_q - 24'd1;           // advance cycle
    activo      = (estado_q == StCarga) || (estado_q == StNota) || (estado_q == StSilencio);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= StIdle;
      addr_q    <= '0;
      cuenta_q  <= '0;
      largo_q   <= '0;
      sonando_q <= 1'b0;
      fin_q     <= 1'b0;
    end else if (estado_q != StIdle && !bus.play) begin
      // Stop and rewind wins over pause.
      estado_q  <= StIdle;
      addr_q    <= '0;
      cuenta_q  <= '0;
      largo_q   <= '0;
      sonando_q <= 1'b0;
      fin_q     <= 1'b0;
    end else if (bus.pause && activo) begin
      sonando_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      unique case (estado_q)
        StIdle: begin
          addr_q    <= '0;
          cuenta_q  <= '0;
          sonando_q <= 1'b0;
          if (bus.play) begin
            estado_q <= StCarga;
          end
        end
        StCarga: begin
          cuenta_q <= '0;
          largo_q  <= largo_nuevo;
          if (bus.duracion_nota == '0) begin
            // End-of-song marker: treated like running past the last note.
            sonando_q <= 1'b0;
            if (bus.loop_en) begin
              addr_q   <= '0;
              estado_q <= StCarga;
            end else begin
              estado_q <= StFin;
              fin_q    <= 1'b1;
            end
          end else begin
            estado_q  <= StNota;
            sonando_q <= 1'b1;
          end
        end
        StNota: begin
          cuenta_q <= cuenta_q + 24'd1;
          if (cuenta_q == fin_sonido) begin
            estado_q  <= StSilencio;
            sonando_q <= 1'b0;
          end else begin
            // Also restores the gate after a pause release.
            sonando_q <= 1'b1;
          end
        end
        StSilencio: begin
          sonando_q <= 1'b0;
          if (cuenta_q == fin_nota) begin
            cuenta_q <= '0;
            if (addr_q != UltimaNota) begin
              addr_q   <= addr_q + ADDR_W'(1);
              estado_q <= StCarga;
            end else if (bus.loop_en) begin
              addr_q   <= '0;
              estado_q <= StCarga;
            end else begin
              estado_q <= StFin;
              fin_q    <= 1'b1;
            end
          end else begin
            cuenta_q <= cuenta_q + 24'd1;
          end
        end
        StFin: begin
          // Address held at the last note until play drops.
          sonando_q <= 1'b0;
        end
        default: begin
          estado_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.direccion_nota  = addr_q;
  assign bus.contador_tiempo = cuenta_q;
  assign bus.sonando         = sonando_q;
  assign bus.fin             = fin_q;

endmodule

// File: tb/tb_secuenciador_notas.sv
module tb_secuenciador_notas;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [3:0] dur_tab [4];

  secuenciador_notas_if #(.ADDR_W(2), .DUR_W(4)) bus ();

  secuenciador_notas #(
    .NUM_NOTAS(4),
    .ADDR_W   (2),
    .DUR_W    (4),
    .TICK_DIV (4),
    .GAP_CYC  (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.duracion_nota = dur_tab[bus.direccion_nota];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_carga(input int a);
    check("carga_addr", 32'(bus.direccion_nota), 32'(a));
    check("carga_count", 32'(bus.contador_tiempo), 0);
    check("carga_son", 32'(bus.sonando), 0);
    check("carga_fin", 32'(bus.fin), 0);
  endtask

  // Called just after CARGA is visible; returns with SILENCIO (advance cycle) visible.
  task automatic nota(input int a, input int d);
    for (int i = 0; i < 4 * d - 1; i++) begin
      tick();
      check("nota_son", 32'(bus.sonando), 1);
      check("nota_count", 32'(bus.contador_tiempo), 32'(i));
      check("nota_addr", 32'(bus.direccion_nota), 32'(a));
    end
    tick();
    check("sil_son", 32'(bus.sonando), 0);
    check("sil_count", 32'(bus.contador_tiempo), 32'(4 * d - 1));
    check("sil_addr", 32'(bus.direccion_nota), 32'(a));
    check("sil_fin", 32'(bus.fin), 0);
  endtask

  task automatic check_idle();
    check("idle_addr", 32'(bus.direccion_nota), 0);
    check("idle_count", 32'(bus.contador_tiempo), 0);
    check("idle_son", 32'(bus.sonando), 0);
    check("idle_fin", 32'(bus.fin), 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    dur_tab[0] = 4'd2;
    dur_tab[1] = 4'd1;
    dur_tab[2] = 4'd3;
    dur_tab[3] = 4'd2;
    rst         = 1'b1;
    bus.play    = 1'b0;
    bus.pause   = 1'b0;
    bus.loop_en = 1'b0;
    tick();
    tick();
    check_idle();

    // Single pass, no loop: 9/5/13/9 cycles, then a one-cycle fin pulse.
    rst      = 1'b0;
    bus.play = 1'b1;
    tick();
    check_carga(0);
    nota(0, 2);
    tick();
    check_carga(1);
    nota(1, 1);
    tick();
    check_carga(2);
    nota(2, 3);
    tick();
    check_carga(3);
    nota(3, 2);
    tick();
    check("fin_pulse", 32'(bus.fin), 1);
    check("fin_addr", 32'(bus.direccion_nota), 3);
    check("fin_son", 32'(bus.sonando), 0);
    tick();
    check("fin_drop", 32'(bus.fin), 0);
    check("fin_hold_addr", 32'(bus.direccion_nota), 3);
    tick();
    check("fin_stay", 32'(bus.fin), 0);
    check("fin_stay_son", 32'(bus.sonando), 0);
    bus.play = 1'b0;
    tick();
    check_idle();

    // Looping: wraps to note 0 without fin, second pass identical; loop_en dropped mid-note 3
    // takes effect at the advance.
    bus.loop_en = 1'b1;
    bus.play    = 1'b1;
    tick();
    check_carga(0);
    for (int p = 0; p < 2; p++) begin
      nota(0, 2);
      tick();
      check_carga(1);
      nota(1, 1);
      tick();
      check_carga(2);
      nota(2, 3);
      tick();
      check_carga(3);
      if (p == 1) bus.loop_en = 1'b0;
      nota(3, 2);
      tick();
      if (p == 0) check_carga(0);
    end
    check("loop_end_fin", 32'(bus.fin), 1);
    check("loop_end_addr", 32'(bus.direccion_nota), 3);
    bus.play = 1'b0;
    tick();
    check_idle();

    // End marker at note 1.
    dur_tab[1] = 4'd0;
    dur_tab[2] = 4'd0;
    dur_tab[3] = 4'd0;
    bus.play   = 1'b1;
    tick();
    check_carga(0);
    nota(0, 2);
    tick();
    check_carga(1);
    tick();
    check("marker_fin", 32'(bus.fin), 1);
    check("marker_addr", 32'(bus.direccion_nota), 1);
    check("marker_son", 32'(bus.sonando), 0);
    bus.play = 1'b0;
    tick();
    check_idle();
    bus.loop_en = 1'b1;
    bus.play    = 1'b1;
    tick();
    check_carga(0);
    nota(0, 2);
    tick();
    check_carga(1);
    tick();
    check_carga(0);
    bus.play = 1'b0;
    tick();
    check_idle();

    // Pause for 10 cycles at count 3 of note 0.
    dur_tab[1]  = 4'd1;
    dur_tab[2]  = 4'd3;
    dur_tab[3]  = 4'd2;
    bus.loop_en = 1'b0;
    bus.play    = 1'b1;
    tick();
    check_carga(0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pre_pause_count", 32'(bus.contador_tiempo), 32'(i));
      check("pre_pause_son", 32'(bus.sonando), 1);
    end
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pause_count", 32'(bus.contador_tiempo), 3);
      check("pause_son", 32'(bus.sonando), 0);
      check("pause_addr", 32'(bus.direccion_nota), 0);
    end
    bus.pause = 1'b0;
    for (int i = 4; i < 7; i++) begin
      tick();
      check("post_pause_count", 32'(bus.contador_tiempo), 32'(i));
      check("post_pause_son", 32'(bus.sonando), 1);
    end
    tick();
    check("post_pause_sil", 32'(bus.contador_tiempo), 7);
    check("post_pause_sil_son", 32'(bus.sonando), 0);
    tick();
    check_carga(1);

    // play dropped during SILENCIO of note 1.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("n1_count", 32'(bus.contador_tiempo), 32'(i));
    end
    tick();
    check("n1_sil_son", 32'(bus.sonando), 0);
    check("n1_sil_count", 32'(bus.contador_tiempo), 3);
    bus.play = 1'b0;
    tick();
    check_idle();

    // Reset in the middle of a note, with play still high.
    bus.play = 1'b1;
    tick();
    check_carga(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pre_rst_count", 32'(bus.contador_tiempo), 32'(i));
    end
    rst = 1'b1;
    tick();
    check_idle();
    tick();
    check_idle();
    rst = 1'b0;
    tick();
    check_carga(0);
    tick();
    check("restart_count", 32'(bus.contador_tiempo), 0);
    check("restart_son", 32'(bus.sonando), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
